store_buffer: RTL and testbench

- Word-store queue between the MEM stage and DataMemory.
- Accepts word stores from the pipeline and retires them to DataMemory one per cycle, in order.
- Shares DataMemory's single address port with loads; loads take priority for the port.
- Resolves load-after-store hazards against pending entries by forwarding or by stalling the load.

---
 rtl/store_buffer_if.sv | 31 +++
 rtl/store_buffer.sv | 134 +++++++++++++
 tb/tb_store_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Pipeline/DataMemory bundle for store_buffer: store and load requests, fence,
// and the shared single-port DataMemory interface.
interface store_buffer_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        fence_req;
    logic        fence_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, fence_req, mem_read_data,
        input  st_ready, ld_ready, ld_data, fence_done,
               mem_addr, mem_write_data, mem_read, mem_write
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, fence_req, mem_read_data,
        output st_ready, ld_ready, ld_data, fence_done,
               mem_addr, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/store_buffer.sv
// In-order word-store buffer sharing DataMemory's port with loads (loads win).
// Define STORE_BUFFER_FORWARD_EN to forward exact-address hits from the youngest store.

// Byte-range overlap of two 4-byte words, unsigned with no wrap past 0xFFFFFFFF.
module sb_overlap (
    input  logic [31:0] st_addr,
    input  logic [31:0] ld_addr,
    output logic        hit
);
    logic [32:0] a, b;
    assign a   = {1'b0, st_addr};
    assign b   = {1'b0, ld_addr};
    assign hit = (a <= b + 33'd3) && (b <= a + 33'd3);
endmodule

module store_buffer #(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t        q [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    logic enq, drain, ld_mem, ovl, fwd;

    assign sb.st_ready = count < CW'(DEPTH);
    assign enq         = sb.st_valid && sb.st_ready;

    // Slots 0..DEPTH-1 are pending entries ordered oldest-first from head;
    // slot DEPTH is the same-cycle incoming store, the youngest of all.
    logic [DEPTH:0][31:0] cmp_addr;
    logic [DEPTH:0]       cmp_vld, hit;
`ifdef STORE_BUFFER_FORWARD_EN
    logic [DEPTH:0][31:0] cmp_data;
`endif

    for (genvar k = 0; k <= DEPTH; k++) begin : g_slot
        if (k < DEPTH) begin : g_ent
            logic [PW-1:0] idx;
            assign idx         = head + PW'(k);
            assign cmp_addr[k] = q[idx].addr;
            assign cmp_vld[k]  = CW'(k) < count;
`ifdef STORE_BUFFER_FORWARD_EN
            assign cmp_data[k] = q[idx].data;
`endif
        end else begin : g_in
            assign cmp_addr[k] = sb.st_addr;
            assign cmp_vld[k]  = enq;
`ifdef STORE_BUFFER_FORWARD_EN
            assign cmp_data[k] = sb.st_data;
`endif
        end
        sb_overlap u_ov (.st_addr(cmp_addr[k]), .ld_addr(sb.ld_addr), .hit(hit[k]));
    end

    always_comb begin
        ovl = 1'b0;
        for (int k = 0; k <= DEPTH; k++)
            if (cmp_vld[k] && hit[k]) ovl = 1'b1;
    end

`ifdef STORE_BUFFER_FORWARD_EN
    logic        yng_exact;
    logic [31:0] yng_data;

    // Ascending scan so the last overlapping slot (the youngest) decides.
    always_comb begin
        yng_exact = 1'b0;
        yng_data  = '0;
        for (int k = 0; k <= DEPTH; k++)
            if (cmp_vld[k] && hit[k]) begin
                yng_exact = (cmp_addr[k] == sb.ld_addr);
                yng_data  = cmp_data[k];
            end
    end
    assign fwd = sb.ld_valid && ovl && yng_exact;
`else
    assign fwd = 1'b0;
`endif

    // Only a non-overlapping load occupies the port, so a stalled load never blocks drain.
    assign ld_mem      = sb.ld_valid && !ovl;
    assign drain       = !rst && !ld_mem && (count != '0);

    assign sb.ld_ready = ld_mem || fwd;
`ifdef STORE_BUFFER_FORWARD_EN
    assign sb.ld_data  = ld_mem ? sb.mem_read_data : (fwd ? yng_data : 32'd0);
`else
    assign sb.ld_data  = ld_mem ? sb.mem_read_data : 32'd0;
`endif
    assign sb.mem_read       = ld_mem;
    assign sb.mem_write      = drain;
    assign sb.mem_addr       = ld_mem ? sb.ld_addr : (drain ? q[head].addr : 32'd0);
    assign sb.mem_write_data = drain ? q[head].data : 32'd0;
    assign sb.fence_done     = (count == '0) && !enq;

    always_ff @(posedge clk) begin
        if (enq) q[tail] <= '{addr: sb.st_addr, data: sb.st_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)   tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            unique case ({enq, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_port_excl: assert property (@(posedge clk) disable iff (rst)
        !(sb.mem_read && sb.mem_write));

    // While fencing, any cycle with a free port and pending work must drain.
    a_fence_drain: assert property (@(posedge clk) disable iff (rst)
        (sb.fence_req && count != '0 && !ld_mem) |-> sb.mem_write);
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a word-indexed combinational DataMemory model.
module tb_store_buffer;
`ifdef STORE_BUFFER_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;

    store_buffer_if sbi ();
    store_buffer #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .sb(sbi.slave));

    always #5 clk = ~clk;

    // Memory initialises to C000_0000 | word_index on reset.
    logic [31:0] mem [256];
    assign sbi.mem_read_data = mem[sbi.mem_addr[9:2]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC000_0000 | 32'(i);
        end else if (sbi.mem_write) begin
            mem[sbi.mem_addr[9:2]] <= sbi.mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        sbi.st_valid = 1'b0;
        sbi.st_addr  = '0;
        sbi.st_data  = '0;
        sbi.ld_valid = 1'b0;
        sbi.ld_addr  = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        sbi.st_valid = 1'b1;
        sbi.st_addr  = a;
        sbi.st_data  = d;
    endtask

    task automatic load(input logic [31:0] a);
        sbi.ld_valid = 1'b1;
        sbi.ld_addr  = a;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        sbi.fence_req = 1'b0;
        idle();

        // Reset
        @(negedge clk);
        chk("rst_mem_write", sbi.mem_write, 0);
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_st_ready", sbi.st_ready, 1);
        chk("rst_mem_write_after", sbi.mem_write, 0);
        chk("rst_mem_read", sbi.mem_read, 0);
        chk("rst_fence_done", sbi.fence_done, 1);
        cyc();

        // 4 back-to-back stores, drain lags by one cycle
        sbi.fence_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) store(32'(4 * i), 32'h11 * 32'(i + 1));
            else idle();
            @(negedge clk);
            if (i < 4) chk("t1_st_ready", sbi.st_ready, 1);
            if (i == 0) begin
                chk("t1_no_write", sbi.mem_write, 0);
                chk("t1_fence_busy", sbi.fence_done, 0);
            end else if (i < 5) begin
                chk("t1_mem_write", sbi.mem_write, 1);
                chk("t1_mem_addr", sbi.mem_addr, 32'(4 * (i - 1)));
                chk("t1_mem_wdata", sbi.mem_write_data, 32'h11 * 32'(i));
            end else begin
                chk("t1_idle_write", sbi.mem_write, 0);
                chk("t1_fence_done", sbi.fence_done, 1);
            end
            if (i == 4) chk("t1_fence_pending", sbi.fence_done, 0);
            cyc();
        end
        sbi.fence_req = 1'b0;

        // Fill while a load stream holds the port
        k = 0;
        for (int i = 0; i < 6; i++) begin
            store(32'h60 + 32'(4 * k), 32'h5000 + 32'(k));
            load(32'h100);
            @(negedge clk);
            chk("t2_st_ready", sbi.st_ready, (i < 4));
            chk("t2_ld_ready", sbi.ld_ready, 1);
            chk("t2_ld_data", sbi.ld_data, 32'hC000_0040);
            chk("t2_mem_read", sbi.mem_read, 1);
            chk("t2_mem_write", sbi.mem_write, 0);
            if (i < 4) k++;
            cyc();
        end
        sbi.ld_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j < 2) chk("t2_st_ready_drain", sbi.st_ready, (j == 1));
            if (j < 5) begin
                chk("t2_drain_write", sbi.mem_write, 1);
                chk("t2_drain_addr", sbi.mem_addr, 32'h60 + 32'(4 * j));
                chk("t2_drain_data", sbi.mem_write_data, 32'h5000 + 32'(j));
            end else begin
                chk("t2_fence_done", sbi.fence_done, 1);
            end
            cyc();
            if (j == 1) sbi.st_valid = 1'b0;
        end

        // Same-cycle store and exact load
        store(32'h20, 32'hDEAD_BEEF);
        load(32'h20);
        @(negedge clk);
        chk("t3_ld_ready", sbi.ld_ready, FWD);
        chk("t3_mem_read", sbi.mem_read, 0);
        chk("t3_mem_write", sbi.mem_write, 0);
        if (FWD) chk("t3_fwd_data", sbi.ld_data, 32'hDEAD_BEEF);
        cyc();
        sbi.st_valid = 1'b0;
        @(negedge clk);
        chk("t3_ld_ready_c1", sbi.ld_ready, FWD);
        chk("t3_drain_write", sbi.mem_write, 1);
        chk("t3_drain_addr", sbi.mem_addr, 32'h20);
        cyc();
        @(negedge clk);
        chk("t3_ld_ready_mem", sbi.ld_ready, 1);
        chk("t3_mem_read_c2", sbi.mem_read, 1);
        chk("t3_ld_data_mem", sbi.ld_data, 32'hDEAD_BEEF);
        cyc();
        idle();

        // Partial overlap stalls in both builds
        store(32'h40, 32'h1234);
        cyc();
        idle();
        load(32'h42);
        @(negedge clk);
        chk("t4_ld_ready", sbi.ld_ready, 0);
        chk("t4_mem_read", sbi.mem_read, 0);
        chk("t4_mem_write", sbi.mem_write, 1);
        chk("t4_mem_addr", sbi.mem_addr, 32'h40);
        cyc();
        @(negedge clk);
        chk("t4_ld_ready_next", sbi.ld_ready, 1);
        chk("t4_ld_data", sbi.ld_data, 32'h1234);
        cyc();
        idle();

        // Youngest of two same-address stores wins
        store(32'h50, 32'hA);
        load(32'h100);
        cyc();
        store(32'h50, 32'hB);
        cyc();
        sbi.st_valid = 1'b0;
        load(32'h50);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j < 2) begin
                chk("t5_ld_ready", sbi.ld_ready, FWD);
                chk("t5_mem_read", sbi.mem_read, 0);
                chk("t5_drain_data", sbi.mem_write_data, (j == 0) ? 32'hA : 32'hB);
                if (FWD) chk("t5_fwd_data", sbi.ld_data, 32'hB);
            end else begin
                chk("t5_ld_ready_mem", sbi.ld_ready, 1);
                chk("t5_ld_data_mem", sbi.ld_data, 32'hB);
            end
            cyc();
        end
        idle();

        // Reset with 3 pending stores discards them
        load(32'h100);
        for (int i = 0; i < 3; i++) begin
            store(32'h80 + 32'(4 * i), 32'h7000 + 32'(i));
            cyc();
        end
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_write", sbi.mem_write, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_fence_done", sbi.fence_done, 1);
        chk("t6_no_write", sbi.mem_write, 0);
        chk("t6_st_ready", sbi.st_ready, 1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            load(32'h80 + 32'(4 * i));
            @(negedge clk);
            chk("t6_ld_ready", sbi.ld_ready, 1);
            chk("t6_ld_data", sbi.ld_data, 32'hC000_0020 + 32'(i));
            chk("t6_write_after", sbi.mem_write, 0);
            cyc();
        end
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
